ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports rd1_d and rd2_d, input, 32 bits each: register-file read data from decode.
REQ-004 SHALL have ports rs1_d, rs2_d and rd_d, input, 5 bits each: source and destination register indices from decode.
REQ-005 SHALL have ports reg_write_d and load_d, input, 1 bit each: decode write-enable and is-load flag.
REQ-006 SHALL have ports stall_e and flush_e, input, 1 bit each: hold or bubble the EX register.
REQ-007 SHALL have ports rd_m (5), reg_write_m (1) and alu_result_m (32), input: memory-stage writeback candidate.
REQ-008 SHALL have ports rd_w (5), reg_write_w (1) and result_w (32), input: writeback-stage result.
REQ-009 SHALL have ports forward_a_e and forward_b_e, output, 2 bits each: operand select codes.
REQ-010 SHALL have ports src_a_e and write_data_e, output, 32 bits each: forwarded operands.
REQ-011 SHALL have ports rd_e (5), reg_write_e (1), load_e (1) and valid_e (1), output: registered EX control.
REQ-012 SHALL have port load_use_stall, output, 1 bit: request to stall fetch/decode and flush EX.
REQ-013 SHALL have port stall_count, output, 16 bits: saturating count of load-use stall cycles.

Function
REQ-014 SHALL register rd1, rd2, rs1, rs2, rd, reg_write and load from the D inputs into E state each cycle when not stalled or flushed, and SHALL set valid_e=1.
REQ-015 SHALL clear all E state to zero and set valid_e=0 on a cycle with flush_e=1; flush_e SHALL take priority over stall_e.
REQ-016 SHALL hold all E state unchanged on a cycle with stall_e=1 and flush_e=0.
REQ-017 SHALL drive forward_a_e=2'b10 when reg_write_m=1, rd_m!=0 and rd_m==rs1_e.
REQ-018 SHALL otherwise drive forward_a_e=2'b01 when reg_write_w=1, rd_w!=0 and rd_w==rs1_e; in all other cases it SHALL drive 2'b00.
REQ-019 SHALL apply the same rules as REQ-017/018 to forward_b_e, using rs2_e.
REQ-020 SHALL never drive select code 2'b11.
REQ-021 SHALL drive src_a_e and write_data_e combinationally: code 00 selects registered rd1/rd2, 01 selects result_w, 10 selects alu_result_m.
REQ-022 SHALL add zero cycles of latency from the E register and the M/W inputs to the src_a_e and write_data_e outputs.
REQ-023 SHALL drive load_use_stall combinationally as valid_e AND load_e AND rd_e!=0 AND (rd_e==rs1_d OR rd_e==rs2_d).
REQ-024 SHALL increment stall_count by 1 on each clock edge where load_use_stall=1.
REQ-025 SHALL hold stall_count at 16'hFFFF once reached; it SHALL NOT wrap.
REQ-026 SHALL continue counting stall_count during stall_e or flush_e cycles.
REQ-027 SHALL NOT clear stall_count on flush_e.

Reset
REQ-028 SHALL, when reset=1 at a clock edge, zero all E state, valid_e, forward codes (derived), stall_count.
REQ-029 SHALL give reset priority over flush_e, stall_e and counter increment.
REQ-030 SHALL, on reset asserted mid-stall, release with stall_count=0 and load_use_stall=0 on the next cycle.

Verification
REQ-031 SHALL cover: rs1_d=5, rd1_d=1 captured; rd_m=5, reg_write_m=1, alu_result_m=2 -> forward_a_e=10, src_a_e=2.
REQ-032 SHALL cover: rs2_e=7, rd_m=7 and rd_w=7, both writing, alu_result_m=2, result_w=4 -> forward_b_e=10, write_data_e=2; then reg_write_m=0 -> 01 and 4.
REQ-033 SHALL cover: rd_m=0, reg_write_m=1, rs1_e=0 -> forward_a_e=00, src_a_e=rd1 value.
REQ-034 SHALL cover: EX holds a load to rd=3 and rs2_d=3 -> load_use_stall=1; then flush_e=1 -> valid_e=0, load_use_stall=0 next cycle.
REQ-035 SHALL cover: stall_e=1 with new D inputs -> E state unchanged; stall_e=1 with flush_e=1 -> cleared.
REQ-036 SHALL cover: 65536 consecutive load-use cycles -> stall_count=16'hFFFF, stays there; then reset=1 -> 0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// EX operand stage: execute pipeline register, operand forwarding from the M/W
// stages, load-use hazard detection and a saturating load-use stall counter.
module ex_operand_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic              reg_write_d,
  input  logic              load_d,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic [4:0]        rd_m,
  input  logic              reg_write_m,
  input  logic [DATA_W-1:0] alu_result_m,
  input  logic [4:0]        rd_w,
  input  logic              reg_write_w,
  input  logic [DATA_W-1:0] result_w,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic [DATA_W-1:0] src_a_e,
  output logic [DATA_W-1:0] write_data_e,
  output logic [4:0]        rd_e,
  output logic              reg_write_e,
  output logic              load_e,
  output logic              valid_e,
  output logic              load_use_stall,
  output logic [15:0]       stall_count
);

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_W   = 2'b01;
  localparam logic [1:0] SEL_M   = 2'b10;

  // E-stage state
  logic [DATA_W-1:0] rd1_p0;
  logic [DATA_W-1:0] rd2_p0;
  logic [4:0]        rs1_p0;
  logic [4:0]        rs2_p0;
  logic [4:0]        rd_p0;
  logic              reg_write_p0;
  logic              load_p0;
  logic              vld_p0;
  logic [15:0]       stall_cnt_p0;

  // The counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Memory stage is the youngest producer, so it wins over writeback; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rdm, input logic wm,
                                         input logic [4:0] rdw, input logic ww);
    if (wm && (rdm != 5'd0) && (rdm == rs))
      return SEL_M;
    else if (ww && (rdw != 5'd0) && (rdw == rs))
      return SEL_W;
    else
      return SEL_REG;
  endfunction

  function automatic logic [DATA_W-1:0] operand_mux(input logic [1:0]        sel,
                                                    input logic [DATA_W-1:0] reg_val,
                                                    input logic [DATA_W-1:0] w_val,
                                                    input logic [DATA_W-1:0] m_val);
    case (sel)
      SEL_W:   return w_val;
      SEL_M:   return m_val;
      default: return reg_val;
    endcase
  endfunction

  // D -> E boundary: flush bubbles the stage and beats stall; stall holds it.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      rd1_p0       <= '0;
      rd2_p0       <= '0;
      rs1_p0       <= '0;
      rs2_p0       <= '0;
      rd_p0        <= '0;
      reg_write_p0 <= 1'b0;
      load_p0      <= 1'b0;
      vld_p0       <= 1'b0;
    end else if (!stall_e) begin
      rd1_p0       <= rd1_d;
      rd2_p0       <= rd2_d;
      rs1_p0       <= rs1_d;
      rs2_p0       <= rs2_d;
      rd_p0        <= rd_d;
      reg_write_p0 <= reg_write_d;
      load_p0      <= load_d;
      vld_p0       <= 1'b1;
    end
  end

  // Stall counter keeps running through stalls and flushes; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_p0 <= '0;
    else if (load_use_stall)
      stall_cnt_p0 <= sat_inc(stall_cnt_p0);
  end

  // Forward select codes and forwarded operands, zero added latency.
  always_comb begin
    forward_a_e  = fwd_sel(rs1_p0, rd_m, reg_write_m, rd_w, reg_write_w);
    forward_b_e  = fwd_sel(rs2_p0, rd_m, reg_write_m, rd_w, reg_write_w);
    src_a_e      = operand_mux(forward_a_e, rd1_p0, result_w, alu_result_m);
    write_data_e = operand_mux(forward_b_e, rd2_p0, result_w, alu_result_m);
  end

  // A valid load in EX whose destination feeds the instruction in decode.
  always_comb begin
    load_use_stall = vld_p0 && load_p0 && (rd_p0 != 5'd0) &&
                     ((rd_p0 == rs1_d) || (rd_p0 == rs2_d));
  end

  assign rd_e        = rd_p0;
  assign reg_write_e = reg_write_p0;
  assign load_e      = load_p0;
  assign valid_e     = vld_p0;
  assign stall_count = stall_cnt_p0;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rd1_d, rd2_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, load_d, stall_e, flush_e;
  logic [4:0]  rd_m, rd_w;
  logic        reg_write_m, reg_write_w;
  logic [31:0] alu_result_m, result_w;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [31:0] src_a_e, write_data_e;
  logic [4:0]  rd_e;
  logic        reg_write_e, load_e, valid_e, load_use_stall;
  logic [15:0] stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the E-stage contents and the stall counter
  logic [31:0] m_rd1, m_rd2;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_rw, m_ld, m_vld;
  int          m_cnt;

  ex_operand_stage dut (
    .clk(clk), .reset(reset),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .load_d(load_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .rd_m(rd_m), .reg_write_m(reg_write_m), .alu_result_m(alu_result_m),
    .rd_w(rd_w), .reg_write_w(reg_write_w), .result_w(result_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .src_a_e(src_a_e), .write_data_e(write_data_e),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .load_e(load_e), .valid_e(valid_e),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which source a register read should take, given who is about to write it.
  function automatic int exp_fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_val(input int code, input logic [31:0] regv);
    if (code == 2) return alu_result_m;
    if (code == 1) return result_w;
    return regv;
  endfunction

  function automatic logic exp_lus();
    return m_vld && m_ld && m_rd != 0 && (m_rd == rs1_d || m_rd == rs2_d);
  endfunction

  task automatic check_all();
    chk("forward_a_e", {30'd0, forward_a_e}, exp_fwd(m_rs1));
    chk("forward_b_e", {30'd0, forward_b_e}, exp_fwd(m_rs2));
    chk("src_a_e", src_a_e, exp_val(exp_fwd(m_rs1), m_rd1));
    chk("write_data_e", write_data_e, exp_val(exp_fwd(m_rs2), m_rd2));
    chk("rd_e", {27'd0, rd_e}, {27'd0, m_rd});
    chk("reg_write_e", {31'd0, reg_write_e}, {31'd0, m_rw});
    chk("load_e", {31'd0, load_e}, {31'd0, m_ld});
    chk("valid_e", {31'd0, valid_e}, {31'd0, m_vld});
    chk("load_use_stall", {31'd0, load_use_stall}, {31'd0, exp_lus()});
    chk("stall_count", {16'd0, stall_count}, m_cnt);
  endtask

  // Advance one clock, updating the model from the inputs the DUT samples.
  task automatic tick();
    logic lus;
    lus = exp_lus();
    @(posedge clk);
    if (reset) begin
      m_cnt = 0;
    end else if (lus) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end
    if (reset || flush_e) begin
      m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
      m_rw = 0; m_ld = 0; m_vld = 0;
    end else if (!stall_e) begin
      m_rd1 = rd1_d; m_rd2 = rd2_d; m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
      m_rw = reg_write_d; m_ld = load_d; m_vld = 1;
    end
    #1;
  endtask

  task automatic clear_inputs();
    rd1_d = 0; rd2_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
    reg_write_d = 0; load_d = 0; stall_e = 0; flush_e = 0;
    rd_m = 0; reg_write_m = 0; alu_result_m = 0;
    rd_w = 0; reg_write_w = 0; result_w = 0;
  endtask

  initial begin
    m_rd1 = 0; m_rd2 = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_rw = 0; m_ld = 0; m_vld = 0; m_cnt = 0;
    clear_inputs();

    // Reset state
    reset = 1;
    tick();
    tick();
    check_all();
    chk("reset_valid", {31'd0, valid_e}, 32'd0);
    chk("reset_count", {16'd0, stall_count}, 32'd0);
    reset = 0;

    // Forward from memory stage to operand A
    rs1_d = 5; rd1_d = 32'd1;
    tick();
    rd_m = 5; reg_write_m = 1; alu_result_m = 32'd2;
    #1;
    check_all();
    chk("fwd_a_mem", {30'd0, forward_a_e}, 32'd2);
    chk("src_a_mem", src_a_e, 32'd2);

    // Memory stage beats writeback on operand B; then writeback alone
    clear_inputs();
    rs2_d = 7; rd2_d = 32'd9;
    tick();
    rd_m = 7; reg_write_m = 1; alu_result_m = 32'd2;
    rd_w = 7; reg_write_w = 1; result_w = 32'd4;
    #1;
    check_all();
    chk("fwd_b_mem", {30'd0, forward_b_e}, 32'd2);
    chk("wd_mem", write_data_e, 32'd2);
    reg_write_m = 0;
    #1;
    check_all();
    chk("fwd_b_wb", {30'd0, forward_b_e}, 32'd1);
    chk("wd_wb", write_data_e, 32'd4);

    // x0 never forwards
    clear_inputs();
    rs1_d = 0; rd1_d = 32'hA5;
    tick();
    rd_m = 0; reg_write_m = 1; alu_result_m = 32'hDEAD;
    #1;
    check_all();
    chk("fwd_a_x0", {30'd0, forward_a_e}, 32'd0);
    chk("src_a_x0", src_a_e, 32'hA5);

    // Load-use hazard, then flush
    clear_inputs();
    load_d = 1; rd_d = 3; reg_write_d = 1;
    tick();
    load_d = 0; rd_d = 0; reg_write_d = 0; rs2_d = 3;
    #1;
    check_all();
    chk("lus_hit", {31'd0, load_use_stall}, 32'd1);
    flush_e = 1;
    tick();
    check_all();
    chk("flush_valid", {31'd0, valid_e}, 32'd0);
    chk("flush_lus", {31'd0, load_use_stall}, 32'd0);
    chk("count_after_lus", {16'd0, stall_count}, 32'd1);

    // Stall holds, stall+flush clears
    clear_inputs();
    rd_d = 12; reg_write_d = 1;
    tick();
    stall_e = 1; rd_d = 20; reg_write_d = 0; load_d = 1;
    tick();
    check_all();
    chk("stall_hold_rd", {27'd0, rd_e}, 32'd12);
    flush_e = 1;
    tick();
    check_all();
    chk("stall_flush_valid", {31'd0, valid_e}, 32'd0);
    chk("stall_flush_rd", {27'd0, rd_e}, 32'd0);

    // Randomized traffic
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      rd1_d        = $urandom;
      rd2_d        = $urandom;
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      rd_d         = 5'($urandom_range(0, 7));
      reg_write_d  = 1'($urandom);
      load_d       = 1'($urandom);
      stall_e      = ($urandom_range(0, 3) == 0);
      flush_e      = ($urandom_range(0, 7) == 0);
      rd_m         = 5'($urandom_range(0, 7));
      reg_write_m  = 1'($urandom);
      alu_result_m = $urandom;
      rd_w         = 5'($urandom_range(0, 7));
      reg_write_w  = 1'($urandom);
      result_w     = $urandom;
      #1;
      check_all();
      tick();
      check_all();
    end

    // Saturation: hold a load-use hazard in EX for more than 65535 cycles
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    load_d = 1; rd_d = 3;
    tick();
    load_d = 0; rd_d = 0; rs2_d = 3; stall_e = 1;
    for (int i = 0; i < 65535; i++) tick();
    check_all();
    chk("sat_reach", {16'd0, stall_count}, 32'h0000FFFF);
    for (int i = 0; i < 5; i++) tick();
    check_all();
    chk("sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
    chk("sat_lus", {31'd0, load_use_stall}, 32'd1);

    // Reset mid-stall wins over stall and increment
    reset = 1;
    tick();
    reset = 0;
    #1;
    check_all();
    chk("reset_mid_count", {16'd0, stall_count}, 32'd0);
    chk("reset_mid_lus", {31'd0, load_use_stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
